// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - 2-master to 1-slave AXI read arbiter, one burst outstanding at a time.
// Define ARB_FIXED_PRIO_EN to give M0 fixed priority instead of round-robin.
module axi_read_arbiter #(
  parameter  int ID_W   = 4,
  parameter  int ADDR_W = 32,
  parameter  int LEN_W  = 4,
  parameter  int DATA_W = 32,
  localparam int ABW    = ID_W + ADDR_W + LEN_W + 5,
  localparam int SW     = ABW + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ABW-1:0]    AR_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  input  logic [ABW-1:0]    AR_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [ID_W-1:0]   RID_M,
  output logic [DATA_W-1:0] RDATA_M,
  output logic [1:0]        RRESP_M,
  output logic              RLAST_M,
  output logic              RVALID_M0,
  output logic              RVALID_M1,
  input  logic              RREADY_M0,
  input  logic              RREADY_M1,
  output logic [SW-1:0]     AR_S,
  output logic              ARVALID_S,
  input  logic              ARREADY_S,
  input  logic [ID_W+3:0]   RID_S,
  input  logic [DATA_W-1:0] RDATA_S,
  input  logic [1:0]        RRESP_S,
  input  logic              RLAST_S,
  input  logic              RVALID_S,
  output logic              RREADY_S
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [SW-1:0] ar_s_q, ar_s_d;
  logic          req_any;
  logic          win;
  logic          rready_sel;
  logic          unused_rid_hi;

  assign req_any = ARVALID_M0 | ARVALID_M1;

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~ARVALID_M0;
`else
  logic last_gnt_q, last_gnt_d;
  // Tie goes to whoever was not granted last; reset value 1 lets M0 win first.
  assign win = (ARVALID_M0 & ARVALID_M1) ? ~last_gnt_q : ARVALID_M1;
`endif

  assign rready_sel    = gnt_q ? RREADY_M1 : RREADY_M0;
  assign RID_M         = RID_S[ID_W-1:0];
  assign RDATA_M       = RDATA_S;
  assign RRESP_M       = RRESP_S;
  assign RLAST_M       = RLAST_S;
  assign AR_S          = ar_s_q;
  assign unused_rid_hi = ^RID_S[ID_W+3:ID_W];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ar_s_d     = ar_s_q;
`ifndef ARB_FIXED_PRIO_EN
    last_gnt_d = last_gnt_q;
`endif
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    ARVALID_S  = 1'b0;
    RVALID_M0  = 1'b0;
    RVALID_M1  = 1'b0;
    RREADY_S   = 1'b0;
    case (state_q)
      IDLE: begin
        // rst gating keeps ARREADY low while reset is held, even with requests pending.
        if (req_any && rst) begin
          ARREADY_M0 = ~win;
          ARREADY_M1 = win;
          gnt_d      = win;
`ifndef ARB_FIXED_PRIO_EN
          last_gnt_d = win;
`endif
          ar_s_d     = {3'b000, win, (win ? AR_M1 : AR_M0)};
          state_d    = ADDR;
        end
      end
      ADDR: begin
        ARVALID_S = 1'b1;
        if (ARREADY_S) state_d = DATA;
      end
      DATA: begin
        RVALID_M0 = RVALID_S & ~gnt_q;
        RVALID_M1 = RVALID_S & gnt_q;
        RREADY_S  = rready_sel;
        if (RVALID_S && rready_sel && RLAST_S) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      ar_s_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ar_s_q     <= ar_s_d;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [44:0] AR_M0, AR_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [48:0] AR_S;
  logic        ARVALID_S, ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S, RVALID_S, RREADY_S;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .AR_M0(AR_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .AR_M1(AR_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
    .AR_S(AR_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_req = 0;
  bit hold = 0;

  logic [36:0] q0[$], q1[$];
  int          glog[$];
  logic [48:0] aslog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [44:0] bnd(input logic [3:0] id, input logic [31:0] a, input logic [3:0] l);
    return {id, a, l, 3'd2, 2'b01};
  endfunction

  function automatic logic [36:0] beat(input logic [7:0] sid, input int i, input int len);
    logic [3:0] b;
    b = i[3:0];
    return {(i == len), sid[3:0], 8'hA0, sid, 12'h000, b};
  endfunction

  // Slave: accepts AR (optionally stalling), then streams ARLEN+1 beats.
  bit         s_busy = 0;
  logic [3:0] s_beat = 0, s_len = 0;
  logic [7:0] s_id = 0;
  int         stall_seen = 0;
  initial begin
    ARREADY_S = 1; RVALID_S = 0; RLAST_S = 0; RID_S = 0; RDATA_S = 0; RRESP_S = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        s_busy = 0; stall_seen = 0;
      end else begin
        if (s_busy && RVALID_S && RREADY_S) begin
          if (s_beat == s_len) s_busy = 0;
          else s_beat = s_beat + 4'd1;
        end
        if (ARVALID_S && ARREADY_S) begin
          s_busy = 1; s_beat = 0; s_len = AR_S[8:5]; s_id = AR_S[48:41];
        end
        if (ARVALID_S && !ARREADY_S) stall_seen++;
      end
      @(posedge clk); #1;
      ARREADY_S = (stall_seen >= stall_req);
      RVALID_S  = s_busy;
      RLAST_S   = s_busy && (s_beat == s_len);
      RID_S     = s_busy ? s_id : 8'h00;
      RDATA_S   = s_busy ? {8'hA0, s_id, 12'h000, s_beat} : 32'h0;
      RRESP_S   = 2'b00;
    end
  end

  // Reference: one owner at a time; free -> grant, address phase, data phase until last beat.
  bit          m_busy = 0, m_addr = 0;
  int          m_own = 0, m_pref = 0, w;
  logic [48:0] m_ar = '0;
  bit          e_ar0, e_ar1, e_arv, e_rv0, e_rv1, e_rr;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_arready_m0", ARREADY_M0, 0);
      chk("rst_arready_m1", ARREADY_M1, 0);
      chk("rst_arvalid_s", ARVALID_S, 0);
      chk("rst_ar_s", AR_S, 0);
      chk("rst_rvalid_m0", RVALID_M0, 0);
      chk("rst_rvalid_m1", RVALID_M1, 0);
      chk("rst_rready_s", RREADY_S, 0);
      m_busy = 0; m_addr = 0; m_pref = 0; m_ar = '0;
    end else begin
      w = (ARVALID_M0 && ARVALID_M1) ? m_pref : (ARVALID_M1 ? 1 : 0);
      e_ar0 = !m_busy && (ARVALID_M0 || ARVALID_M1) && (w == 0);
      e_ar1 = !m_busy && (ARVALID_M0 || ARVALID_M1) && (w == 1);
      e_arv = m_busy && m_addr;
      e_rr  = m_busy && !m_addr && ((m_own == 0) ? RREADY_M0 : RREADY_M1);
      e_rv0 = m_busy && !m_addr && (m_own == 0) && RVALID_S;
      e_rv1 = m_busy && !m_addr && (m_own == 1) && RVALID_S;
      chk("arready_m0", ARREADY_M0, e_ar0);
      chk("arready_m1", ARREADY_M1, e_ar1);
      chk("arvalid_s", ARVALID_S, e_arv);
      chk("ar_s", AR_S, m_ar);
      chk("rvalid_m0", RVALID_M0, e_rv0);
      chk("rvalid_m1", RVALID_M1, e_rv1);
      chk("rready_s", RREADY_S, e_rr);
      chk("rid_m", RID_M, RID_S[3:0]);
      chk("rdata_m", RDATA_M, RDATA_S);
      chk("rlast_m", RLAST_M, RLAST_S);
      if (ARVALID_M0 && ARREADY_M0) glog.push_back(0);
      if (ARVALID_M1 && ARREADY_M1) glog.push_back(1);
      if (ARVALID_S && ARREADY_S) aslog.push_back(AR_S);
      if (RVALID_M0 && RREADY_M0) q0.push_back({RLAST_M, RID_M, RDATA_M});
      if (RVALID_M1 && RREADY_M1) q1.push_back({RLAST_M, RID_M, RDATA_M});
      if (!m_busy) begin
        if (ARVALID_M0 || ARVALID_M1) begin
          m_busy = 1; m_addr = 1; m_own = w;
          m_ar = {3'b000, w[0], (w == 1) ? AR_M1 : AR_M0};
`ifndef ARB_FIXED_PRIO_EN
          m_pref = 1 - w;
`endif
        end
      end else if (m_addr) begin
        if (ARREADY_S) m_addr = 0;
      end else if (RVALID_S && e_rr && RLAST_S) begin
        m_busy = 0;
      end
    end
  end

  // One cycle; a granted AR is withdrawn afterwards unless hold is set.
  task automatic step();
    bit h0, h1;
    @(negedge clk);
    h0 = ARVALID_M0 && ARREADY_M0;
    h1 = ARVALID_M1 && ARREADY_M1;
    @(posedge clk); #1;
    if (h0 && !hold) ARVALID_M0 = 0;
    if (h1 && !hold) ARVALID_M1 = 0;
  endtask

  task automatic wait_beats(input int which, input int n, input string nm);
    int k = 0;
    while (((which == 0) ? q0.size() : q1.size()) < n && k < 300) begin
      step(); k++;
    end
    chk(nm, (which == 0) ? q0.size() : q1.size(), n);
  endtask

  task automatic do_reset();
    rst = 0; stall_req = 0; hold = 0;
    ARVALID_M0 = 0; ARVALID_M1 = 0; RREADY_M0 = 1; RREADY_M1 = 1;
    step(); step();
    rst = 1;
    q0.delete(); q1.delete(); glog.delete(); aslog.delete();
    step();
  endtask

  int exp_g[4];

  initial begin
    rst = 0; AR_M0 = '0; AR_M1 = '0; ARVALID_M0 = 0; ARVALID_M1 = 0;
    RREADY_M0 = 1; RREADY_M1 = 1;
    #2;
    chk("reset_arvalid_s", ARVALID_S, 0);
    chk("reset_ar_s", AR_S, 0);
    do_reset();

    // 1: single M0 burst of 4 beats
    AR_M0 = bnd(4'h2, 32'h10, 4'd3); ARVALID_M0 = 1;
    #1 chk("t1_arready_m0_c0", ARREADY_M0, 1);
    chk("t1_arvalid_s_c0", ARVALID_S, 0);
    step();
    chk("t1_arvalid_s_c1", ARVALID_S, 1);
    chk("t1_arid_s", AR_S[48:41], 8'h02);
    chk("t1_model_arid", m_ar[48:41], 8'h02);
    chk("t1_araddr_s", AR_S[40:9], 32'h10);
    wait_beats(0, 4, "t1_beats");
    for (int i = 0; i < 4; i++) chk($sformatf("t1_beat%0d", i), q0[i], beat(8'h02, i, 3));
    chk("t1_no_m1_beats", q1.size(), 0);

    // 2: both valid right after reset
    do_reset();
    AR_M0 = bnd(4'h3, 32'h20, 4'd1); AR_M1 = bnd(4'h5, 32'h30, 4'd1);
    ARVALID_M0 = 1; ARVALID_M1 = 1;
    wait_beats(0, 2, "t2_m0_beats");
    wait_beats(1, 2, "t2_m1_beats");
    chk("t2_grant0", glog[0], 0);
    chk("t2_grant1", glog[1], 1);
    chk("t2_arid_s0", aslog[0][48:41], 8'h03);
    chk("t2_arid_s1", aslog[1][48:41], 8'h15);
    for (int i = 0; i < 2; i++) chk($sformatf("t2_m1_beat%0d", i), q1[i], beat(8'h15, i, 1));

    // 3: both held valid over 4 bursts
    do_reset();
    hold = 1;
    AR_M0 = bnd(4'h1, 32'h0, 4'd0); AR_M1 = bnd(4'h2, 32'h0, 4'd0);
    ARVALID_M0 = 1; ARVALID_M1 = 1;
    begin
      int k = 0;
      while (glog.size() < 4 && k < 300) begin step(); k++; end
    end
    hold = 0; ARVALID_M0 = 0; ARVALID_M1 = 0;
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    chk("t3_grant_count", glog.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), glog[i], exp_g[i]);

    // 4: slave holds ARREADY low for 5 address cycles
    do_reset();
    stall_req = 5;
    step();
    AR_M0 = bnd(4'h1, 32'h40, 4'd0); ARVALID_M0 = 1;
    #1 chk("t4_arready_m0", ARREADY_M0, 1);
    step();
    AR_M1 = bnd(4'h7, 32'h50, 4'd0); ARVALID_M1 = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_arvalid_s", ARVALID_S, 1);
      chk("t4_ar_s", AR_S, {4'b0000, bnd(4'h1, 32'h40, 4'd0)});
      chk("t4_arready_m0", ARREADY_M0, 0);
      chk("t4_arready_m1", ARREADY_M1, 0);
      step();
    end
    chk("t4_no_ar_hs_yet", aslog.size(), 0);
    wait_beats(0, 1, "t4_m0_beats");
    wait_beats(1, 1, "t4_m1_beats");
    chk("t4_m1_beat", q1[0], beat(8'h17, 0, 0));

    // 5: M1 stalls 3 cycles on beat 2
    do_reset();
    AR_M1 = bnd(4'h6, 32'h80, 4'd3); ARVALID_M1 = 1;
    wait_beats(1, 1, "t5_first_beat");
    RREADY_M1 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_rready_s", RREADY_S, 0);
      chk("t5_rvalid_m1", RVALID_M1, 1);
      chk("t5_rvalid_m0", RVALID_M0, 0);
      chk("t5_rdata_held", RDATA_M, beat(8'h16, 1, 3) & 37'h0_FFFF_FFFF);
      step();
    end
    RREADY_M1 = 1;
    wait_beats(1, 4, "t5_beats");
    for (int i = 0; i < 4; i++) chk($sformatf("t5_beat%0d", i), q1[i], beat(8'h16, i, 3));
    step(); step();
    chk("t5_no_dup", q1.size(), 4);

    // 6: reset during beat 2 of 4, then a fresh M1 burst
    do_reset();
    AR_M0 = bnd(4'h4, 32'h100, 4'd3); ARVALID_M0 = 1;
    wait_beats(0, 1, "t6_first_beat");
    rst = 0;
    AR_M1 = bnd(4'h9, 32'h200, 4'd3); ARVALID_M1 = 1;
    #1;
    chk("t6_arvalid_s", ARVALID_S, 0);
    chk("t6_ar_s", AR_S, 0);
    chk("t6_arready_m0", ARREADY_M0, 0);
    chk("t6_arready_m1", ARREADY_M1, 0);
    chk("t6_rvalid_m0", RVALID_M0, 0);
    chk("t6_rvalid_m1", RVALID_M1, 0);
    chk("t6_rready_s", RREADY_S, 0);
    step(); step();
    rst = 1;
    #1 chk("t6_arready_m1_after", ARREADY_M1, 1);
    wait_beats(1, 4, "t6_m1_beats");
    chk("t6_arid_s", aslog[aslog.size()-1][48:41], 8'h19);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_beat%0d", i), q1[i], beat(8'h19, i, 3));
    chk("t6_m0_dropped", q0.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
